// File: rtl/spi_pkg.sv
// Shared constants for the multi-slave SPI master: FSM encoding and SPI mode bits.
package spi_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SETUP = ST_SETUP,
    S_SHIFT = ST_SHIFT,
    S_HOLD  = ST_HOLD
  } spi_state_e;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: single-cycle tick every div+1 clk cycles while enabled.
module spi_clk_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  // One extra bit so an all-ones divider never wraps before matching.
  logic [DIV_W:0] cnt;

  assign tick = en && (cnt == {1'b0, div});

  always_ff @(posedge clk or posedge reset)
    if (reset)           cnt <= '0;
    else if (!en || tick) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master with per-transfer mode, divider and slave select.
// Optional macro SPI_LSB_FIRST_EN adds a lsb_first input for LSB-first shifting.
module spi_master_mc
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8,
  localparam int SS_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              busy,
  output logic              done,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);
  localparam int EC_W = $clog2(2*DATA_W) + 1;
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2*DATA_W - 1);

  spi_state_e        state, nxt;
  logic              accept, tick, cpha_q, lsb_q, sclk_q, done_q;
  logic [SS_W-1:0]   ss_q;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_sh, rx_sh, rx_q;
  logic [EC_W-1:0]   ecnt;

  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign rx_valid = done_q;
  assign rx_data  = rx_q;
  assign sclk     = sclk_q;
  assign mosi     = (state == S_IDLE) ? 1'b0 : (lsb_q ? tx_sh[0] : tx_sh[DATA_W-1]);

  spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
    .clk(clk), .reset(reset), .en(busy), .div(div_q), .tick(tick)
  );

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= nxt;

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    case (state)
      S_IDLE:  if (start && (32'(ss_sel) < 32'(NUM_SS))) begin
                 nxt    = S_SETUP;
                 accept = 1'b1;
               end
      S_SETUP: if (tick) nxt = S_SHIFT;
      S_SHIFT: if (tick && ecnt == LAST_EDGE) nxt = S_HOLD;
      S_HOLD:  if (tick) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Same slave requested in the done cycle keeps its select low across words.
  always_comb begin
    ss_n = '1;
    if (busy || (done_q && start && ss_sel == ss_q)) ss_n[ss_q] = 1'b0;
  end

`ifdef SPI_LSB_FIRST_EN
  always_ff @(posedge clk or posedge reset)
    if (reset)       lsb_q <= 1'b0;
    else if (accept) lsb_q <= lsb_first;
`else
  assign lsb_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cpha_q <= 1'b0;
      ss_q   <= '0;
      div_q  <= '0;
      tx_sh  <= '0;
      rx_sh  <= '0;
      rx_q   <= '0;
      ecnt   <= '0;
      sclk_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) sclk_q <= mode[CPOL_BIT];
      if (accept) begin
        cpha_q <= mode[CPHA_BIT];
        ss_q   <= ss_sel;
        div_q  <= clk_div;
        tx_sh  <= tx_data;
        rx_sh  <= '0;
        ecnt   <= '0;
      end
      if (state == S_SHIFT && tick) begin
        sclk_q <= ~sclk_q;
        ecnt   <= ecnt + 1'b1;
        // Even edge counts are leading edges; CPHA picks which edge samples.
        if (ecnt[0] == cpha_q)
          rx_sh <= lsb_q ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        else if (!(cpha_q && ecnt == '0))
          tx_sh <= lsb_q ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
      end
      if (state == S_HOLD && tick) begin
        done_q <= 1'b1;
        rx_q   <= rx_sh;
      end
    end
endmodule

// File: tb/tb_spi_master_mc.sv
// Randomized bench for spi_master_mc against a behavioural SPI slave model.
`timescale 1ns/1ps
module tb_spi_master_mc;
  import spi_pkg::*;
  localparam int DW = 8, NSS = 3, DVW = 8, PER = 10;

  logic           clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [1:0]     mode = '0;
  logic [1:0]     ss_sel = '0;
  logic [DVW-1:0] clk_div = '0;
  logic [DW-1:0]  tx_data = '0;
`ifdef SPI_LSB_FIRST_EN
  logic           lsb_first = 1'b0;
`endif
  logic           busy, done, rx_valid, sclk, mosi;
  logic [DW-1:0]  rx_data;
  logic [NSS-1:0] ss_n;
  logic           miso = 1'b0;

  always #(PER/2) clk = ~clk;

  spi_master_mc #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DVW)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ss_sel(ss_sel),
    .clk_div(clk_div), .tx_data(tx_data),
`ifdef SPI_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .busy(busy), .done(done), .rx_valid(rx_valid), .rx_data(rx_data),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  int n_cmp = 0, n_err = 0, n_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) if (done) n_done++;

  // Behavioural SPI slave: standard CPOL/CPHA rules, also times SCLK half-periods.
  logic          cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
  int            cur_h = 1;
  logic [DW-1:0] s_tx = '0, s_rx = '0;
  int            oi = 0, ii = 0, edges = 0;
  time           t_last = 0;
  logic          ss_prev = 1'b1, sclk_prev = 1'b0;
  wire           ss_any = &ss_n;

  function automatic int ord(input int i);
    return cur_lsb ? i : DW-1-i;
  endfunction

  always @(ss_any or sclk) begin
    if (ss_prev && !ss_any) begin
      oi = 0; ii = 0; edges = 0; s_rx = '0; t_last = $time;
      if (!cur_cpha) begin miso = s_tx[ord(0)]; oi = 1; end
    end else if (!ss_any && !reset && sclk !== sclk_prev) begin
      chk("half_period", 32'(($time - t_last) / PER), (edges == 0) ? 2*cur_h : cur_h);
      t_last = $time;
      edges++;
      if ((sclk != cur_cpol) ^ cur_cpha) begin
        if (ii < DW) s_rx[ord(ii)] = mosi;
        ii++;
      end else begin
        if (oi < DW) miso = s_tx[ord(oi)];
        oi++;
      end
    end
    ss_prev = ss_any;
    sclk_prev = sclk;
  end

  task automatic setup_cfg(input logic [1:0] m, input int sel, input logic [7:0] div,
                           input logic [7:0] tx, input logic [7:0] stx, input logic lsb);
    mode = m; ss_sel = 2'(sel); clk_div = div; tx_data = tx;
`ifdef SPI_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    cur_cpol = m[1]; cur_cpha = m[0]; cur_lsb = lsb; cur_h = int'(div) + 1; s_tx = stx;
  endtask

  task automatic xfer(input logic [1:0] m, input int sel, input logic [7:0] div,
                      input logic [7:0] tx, input logic [7:0] stx, input logic lsb, input int poke);
    int cyc, nd0;
    logic [NSS-1:0] exp_ss;
    exp_ss = ~(3'b001 << sel);
    @(negedge clk); setup_cfg(m, sel, div, tx, stx, lsb);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd0 = n_done;
    chk("busy_rise", busy, 1);
    chk("ss_n_sel", ss_n, exp_ss);
    if (!m[0]) chk("mosi_first", mosi, lsb ? tx[0] : tx[7]);
    cyc = 0;
    while (!done && cyc < 20*(int'(div)+1) + 10) begin
      if (cyc == poke) begin
        start = 1'b1; ss_sel = 2'((sel + 1) % NSS);
      end else if (cyc == poke + 1) begin
        start = 1'b0;
        chk("ignore_ss", ss_n, exp_ss);
        chk("ignore_busy", busy, 1);
      end
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, 18*(int'(div)+1));
    chk("rx_valid", rx_valid, 1);
    chk("busy_fall", busy, 0);
    chk("rx_data", rx_data, stx);
    chk("mosi_word", s_rx, tx);
    chk("sclk_edges", edges, 2*DW);
    chk("ss_release", ss_n, 3'b111);
    chk("sclk_idle", sclk, m[1]);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("done_count", n_done - nd0, 1);
  endtask

  initial begin
    #(10_000*PER*10);
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nd0;
    logic lsbr;
    #1 reset = 1'b1;
    #5;
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_rxv", rx_valid, 0);  chk("rst_rxd", rx_data, 0);
    chk("rst_sclk", sclk, 0);     chk("rst_mosi", mosi, 0);
    chk("rst_ss_n", ss_n, 3'b111);
    @(negedge clk); reset = 1'b0;

    xfer(SPI_MODE0, 2, 8'd0, 8'hA5, 8'h3C, 1'b0, -1);
    xfer(SPI_MODE1, 1, 8'd3, 8'h96, 8'h5A, 1'b0, -1);
    xfer(SPI_MODE2, 0, 8'd3, 8'h96, 8'hC3, 1'b0, -1);
    xfer(SPI_MODE3, 2, 8'd3, 8'h96, 8'h69, 1'b0, 20);

    // out-of-range select is ignored
    nd0 = n_done;
    @(negedge clk); ss_sel = 2'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("oor_busy", busy, 0);
    chk("oor_ss_n", ss_n, 3'b111);
    repeat (5) @(negedge clk);
    chk("oor_no_done", n_done - nd0, 0);

    xfer(SPI_MODE2, 1, 8'hFF, 8'h3D, 8'hB2, 1'b0, -1);

    // back-to-back, slave 0 then slave 1
    @(negedge clk); setup_cfg(SPI_MODE0, 0, 8'd0, 8'h5C, 8'hE1, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); ss_sel = 2'd1; tx_data = 8'h3B; nd0 = n_done;
    chk("b2b_ss0", ss_n, 3'b110);
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    chk("b2b_rx0", rx_data, 8'hE1);
    chk("b2b_mosi0", s_rx, 8'h5C);
    chk("b2b_gap", ss_n, 3'b111);
    s_tx = 8'h7E;
    @(negedge clk); start = 1'b0;
    chk("b2b_ss1", ss_n, 3'b101);
    chk("b2b_busy1", busy, 1);
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    chk("b2b_rx1", rx_data, 8'h7E);
    chk("b2b_mosi1", s_rx, 8'h3B);
    @(negedge clk);
    chk("b2b_dones", n_done - nd0, 2);

    // asynchronous reset at SHIFT edge 5
    @(negedge clk); setup_cfg(SPI_MODE3, 1, 8'd1, 8'hE7, 8'h18, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nd0 = n_done; k = 0;
    while (edges < 5 && k < 100) begin @(negedge clk); k++; end
    chk("rst_edge5", edges, 5);
    #2 reset = 1'b1;
    #1;
    chk("arst_ss_n", ss_n, 3'b111); chk("arst_busy", busy, 0);
    chk("arst_sclk", sclk, 0);      chk("arst_mosi", mosi, 0);
    chk("arst_done", done, 0);      chk("arst_rxv", rx_valid, 0);
    chk("arst_rxd", rx_data, 0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", n_done - nd0, 0);
    xfer(SPI_MODE1, 0, 8'd1, 8'h4B, 8'hD2, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      lsbr = 1'b0;
`ifdef SPI_LSB_FIRST_EN
      lsbr = 1'($urandom);
`endif
      xfer(2'($urandom_range(0, 3)), int'($urandom_range(0, NSS-1)), 8'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), lsbr, -1);
    end

`ifdef SPI_LSB_FIRST_EN
    xfer(SPI_MODE0, 1, 8'd0, 8'h01, 8'h80, 1'b1, -1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
